// File: rtl/half_adder.sv
// half_adder: WIDTH independent half-adder lanes.
// - sum/carry are purely combinational from a and b.
// - sum_q/carry_q/out_valid hold a one-cycle registered copy of accepted operands.
// - carry_cnt counts accepted cycles with at least one carrying lane and saturates at all-ones.
// Optional build macro HA_SELFCHECK_EN adds the err_sticky output and a registered
// consistency checker on the registered result.
// All registered state uses a synchronous active-high reset (rst).

module half_adder #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
`ifdef HA_SELFCHECK_EN
    ,
    output logic             err_sticky
`endif
);

    // Combinational lane results.
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_any_carry;
    logic             w_cnt_max;
    logic             w_cnt_inc;

    // Registered state.
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    assign w_sum       = a ^ b;
    assign w_carry     = a & b;
    assign w_any_carry = |w_carry;
    assign w_cnt_max   = (r_cnt == {CNT_W{1'b1}});
    // Increment only on accepted carrying cycles, and never past all-ones.
    assign w_cnt_inc   = in_valid & w_any_carry & ~w_cnt_max;

    assign sum       = w_sum;
    assign carry     = w_carry;
    assign sum_q     = r_sum;
    assign carry_q   = r_carry;
    assign out_valid = r_valid;
    assign carry_cnt = r_cnt;
    assign cnt_sat   = w_cnt_max;

    // Result registers: capture on accepted cycles, otherwise hold; valid always tracks in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
            end
        end
    end

    // Saturating carry-event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef HA_SELFCHECK_EN
    // Operand copies that the registered result is checked against.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_lane_bad;
    logic             r_err;

    assign err_sticky = r_err;

    // Capture operands alongside the registered result so both describe the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (in_valid) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Per lane, the 2-bit value {carry_q, sum_q} must equal a_q + b_q.
    always_comb begin
        w_lane_bad = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_lane_bad[i] = ({r_carry[i], r_sum[i]} != ({1'b0, r_a[i]} + {1'b0, r_b[i]}));
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_valid && (|w_lane_bad)) begin
            r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder. Two instances share clock/reset/valid:
// an 8-lane copy with a 4-bit counter (saturation reachable quickly) and a
// single-lane copy with the default 16-bit counter driven from lane 0.
// Expected values come from a lane-wise arithmetic model (a+b split into
// sum/carry bits) and an integer saturating counter.

module tb_half_adder;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;

    logic [7:0] sum8, carry8, sum_q8, carry_q8;
    logic       out_valid8, cnt_sat8;
    logic [3:0] carry_cnt8;

    logic [0:0]  sum1, carry1, sum_q1, carry_q1;
    logic        out_valid1, cnt_sat1;
    logic [15:0] carry_cnt1;

`ifdef HA_SELFCHECK_EN
    logic err8;
    logic err1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] m_sum_q, m_carry_q;
    logic       m_valid;
    int         m_cnt8, m_cnt1;

    half_adder #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .sum       (sum8),
        .carry     (carry8),
        .sum_q     (sum_q8),
        .carry_q   (carry_q8),
        .out_valid (out_valid8),
        .carry_cnt (carry_cnt8),
        .cnt_sat   (cnt_sat8)
`ifdef HA_SELFCHECK_EN
        ,
        .err_sticky(err8)
`endif
    );

    half_adder #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a[0:0]),
        .b         (b[0:0]),
        .in_valid  (in_valid),
        .sum       (sum1),
        .carry     (carry1),
        .sum_q     (sum_q1),
        .carry_q   (carry_q1),
        .out_valid (out_valid1),
        .carry_cnt (carry_cnt1),
        .cnt_sat   (cnt_sat1)
`ifdef HA_SELFCHECK_EN
        ,
        .err_sticky(err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane-wise arithmetic: each lane's 2-bit a+b gives {carry, sum}.
    function automatic logic [15:0] lane_add(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] s, c;
        int t;
        for (int i = 0; i < 8; i++) begin
            t    = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    task automatic check_comb(input string tag);
        logic [15:0] r;
        r = lane_add(a, b);
        check({tag, ".sum8"},   64'(sum8),   64'(r[7:0]));
        check({tag, ".carry8"}, 64'(carry8), 64'(r[15:8]));
        check({tag, ".sum1"},   64'(sum1),   64'(r[0]));
        check({tag, ".carry1"}, 64'(carry1), 64'(r[8]));
    endtask

    // Advance one clock: update the model from the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        logic [15:0] r;
        r = lane_add(a, b);
        if (rst) begin
            m_sum_q = '0; m_carry_q = '0; m_valid = 1'b0; m_cnt8 = 0; m_cnt1 = 0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_sum_q   = r[7:0];
                m_carry_q = r[15:8];
                if (r[15:8] != 0) m_cnt8 = (m_cnt8 + 1 > 15) ? 15 : m_cnt8 + 1;
                if (r[8])         m_cnt1 = (m_cnt1 + 1 > 65535) ? 65535 : m_cnt1 + 1;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".sum_q8"},   64'(sum_q8),     64'(m_sum_q));
        check({tag, ".carry_q8"}, 64'(carry_q8),   64'(m_carry_q));
        check({tag, ".valid8"},   64'(out_valid8), 64'(m_valid));
        check({tag, ".cnt8"},     64'(carry_cnt8), 64'(m_cnt8));
        check({tag, ".sat8"},     64'(cnt_sat8),   64'(m_cnt8 == 15));
        check({tag, ".sum_q1"},   64'(sum_q1),     64'(m_sum_q[0]));
        check({tag, ".carry_q1"}, 64'(carry_q1),   64'(m_carry_q[0]));
        check({tag, ".valid1"},   64'(out_valid1), 64'(m_valid));
        check({tag, ".cnt1"},     64'(carry_cnt1), 64'(m_cnt1));
        check({tag, ".sat1"},     64'(cnt_sat1),   64'(m_cnt1 == 65535));
`ifdef HA_SELFCHECK_EN
        check({tag, ".err8"}, 64'(err8), 64'(0));
        check({tag, ".err1"}, 64'(err1), 64'(0));
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        m_sum_q = '0; m_carry_q = '0; m_valid = 1'b0; m_cnt8 = 0; m_cnt1 = 0;

        // Single-lane truth table on the combinational path, 10 ns per pattern.
        for (int i = 0; i < 4; i++) begin
            a = {7'b0, i[1]};
            b = {7'b0, i[0]};
            #10;
            check($sformatf("tt%0d.sum1", i),   64'(sum1),   64'(i == 1 || i == 2));
            check($sformatf("tt%0d.carry1", i), 64'(carry1), 64'(i == 3));
        end

        // Two reset cycles, then the reset state.
        a = '0; b = '0;
        tick("rst0");
        tick("rst1");

        // First accepted operand pair.
        rst = 1'b0; in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
        #1 check_comb("f0_3c");
        tick("f0_3c");
        check("f0_3c.sum_q_const", 64'(sum_q8), 64'h0000_0000_0000_00CC);
        check("f0_3c.carry_q_const", 64'(carry_q8), 64'h0000_0000_0000_0030);
        check("f0_3c.cnt_const", 64'(carry_cnt8), 64'd1);

        // Hold: not valid, combinational path still follows a and b.
        in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
        #1 check_comb("hold");
        check("hold.sum_const", 64'(sum8), 64'h0);
        check("hold.carry_const", 64'(carry8), 64'hFF);
        tick("hold");
        check("hold.sum_q_const", 64'(sum_q8), 64'hCC);

        // Saturation of the 4-bit counter.
        in_valid = 1'b1; a = 8'h01; b = 8'h01;
        for (int i = 0; i < 20; i++) tick($sformatf("sat%0d", i));
        check("sat.cnt_const", 64'(carry_cnt8), 64'd15);
        check("sat.flag_const", 64'(cnt_sat8), 64'd1);

        // Reset mid-stream with valid carrying input on the reset edge.
        rst = 1'b1;
        tick("midrst");
        check("midrst.cnt_const", 64'(carry_cnt8), 64'd0);
        rst = 1'b0;
        tick("postrst");
        check("postrst.cnt_const", 64'(carry_cnt8), 64'd1);

        // Random operands and valid.
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            #1 check_comb($sformatf("rnd%0d", i));
            tick($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bit-parallel half adder: WIDTH independent lanes, each computing sum = a XOR b and carry = a AND b.
- Combinational outputs are available with zero latency, so a bench with no clock can check them after any settle delay.
- A registered copy of the result is also provided with a valid flag, plus a saturating carry-event counter.
- Used as a leaf arithmetic primitive and as a bring-up and teaching block.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (legal range 1 to 64).
- CNT_W, 16, width of the carry-event counter (legal range 4 to 32).

Ports:
- clk  input  1  rising-edge clock for all registered logic.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies a and b for the registered path.
- sum  output  WIDTH  combinational a XOR b, per lane.
- carry  output  WIDTH  combinational a AND b, per lane.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  registered in_valid.
- carry_cnt  output  CNT_W  count of accepted cycles in which any lane carried.
- cnt_sat  output  1  high while carry_cnt equals all-ones.

Behaviour:
Combinational path:
- sum and carry depend only on a and b; they ignore clk, rst and in_valid.
- Truth table per lane (a, b -> sum, carry): 00 -> 0,0; 01 -> 1,0; 10 -> 1,0; 11 -> 0,1.
- For X or Z inputs, standard Verilog XOR/AND semantics apply.

Reset:
- On a rising clk with rst=1: sum_q, carry_q, out_valid, carry_cnt and cnt_sat all become 0.
- rst has priority over in_valid on the same edge.
- The combinational path is unaffected by reset.

Registered path (1-cycle latency):
- On each rising clk with rst=0, sum_q <= a^b, carry_q <= a&b and out_valid <= in_valid.
- If in_valid=0, sum_q and carry_q hold their previous values; only out_valid updates (to 0).
- There is no backpressure. Every in_valid cycle is accepted.

Counter:
- On a rising clk with rst=0, in_valid=1 and (a&b) != 0, carry_cnt increments by 1.
- It saturates at 2^CNT_W-1 and never wraps.
- cnt_sat is combinational from carry_cnt (carry_cnt == all-ones).
- Only synchronous reset clears the counter.

Boundary conditions:
- If reset is asserted mid-stream, the next cycle shows out_valid=0 and carry_cnt=0, regardless of in_valid on the reset edge.
- When in_valid=1 with a carry occurs at saturation, carry_cnt stays at max and cnt_sat stays 1.
- With WIDTH=1, the block behaves as a classic single-bit half adder, plus its registers.

Optional Feature:
- Macro: HA_SELFCHECK_EN.
- When defined, a registered checker is added and a 1-bit output port err_sticky appears.
- Each rising clk with rst=0 and out_valid=1, every lane is checked: sum_q + 2*carry_q must equal a_q + b_q, where a_q and b_q are registered copies of the accepted operands.
- Any mismatch sets err_sticky=1. It stays set until rst.
- Reset value of err_sticky is 0.
- When not defined, the port, the operand registers and the checker are absent.
- All other behaviour is identical with or without the macro.

Test Plan:
- WIDTH=1, no clock toggling; apply a,b = 00, 01, 10, 11 at 10 ns intervals. Required sum,carry = 0,0 / 1,0 / 1,0 / 0,1 within each interval.
- WIDTH=8, rst=1 for 2 cycles then 0; in_valid=1 with a=0xF0, b=0x3C. Next cycle: sum_q=0xCC, carry_q=0x30, out_valid=1, carry_cnt=1.
- Hold check: set in_valid=0 and change a=0xFF, b=0xFF. Required: sum_q and carry_q hold 0xCC and 0x30, out_valid=0, carry_cnt unchanged. Combinational sum=0x00 and carry=0xFF immediately.
- CNT_W=4, in_valid=1, a=b=1 for 20 cycles. Required: carry_cnt climbs to 15 and stays there, cnt_sat=1 from cycle 15 onward.
- Reset mid-stream: in_valid=1, a=b=1, rst=1 for one cycle. Next cycle: out_valid=0 and carry_cnt=0. The edge after rst deasserts: carry_cnt=1.
- With HA_SELFCHECK_EN defined, run random a,b for 1000 cycles. Required: err_sticky remains 0.
